// File: rtl/slow_xfer_pkg.sv
// Shared defaults and width helpers for the fast-to-slow transfer bridge.
package slow_xfer_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 8;

    // Pointer width; kept at least 1 so degenerate depths still elaborate.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy needs one extra bit to represent the completely full state.
    function automatic int cnt_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } slow_edge_t;

endpackage

// File: rtl/xfer_sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers and an explicit occupancy count.
module xfer_sync_fifo
    import slow_xfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = addr_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset so it maps onto memory primitives.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Head word is always visible so the consumer can capture it on the pop edge.
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/slow_clk_xfer.sv
// Buffers fast-clock words and presents them one per slow_clk period, updating
// only on the clk cycle after each detected slow_clk rising edge.
module slow_clk_xfer
    import slow_xfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slow_clk,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              slow_rise,
    output logic              slow_fall,
    output logic [CNT_W-1:0]  fifo_cnt
);

    logic              slow_d_reg;
    slow_edge_t        edge_det;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              out_valid_reg;
    logic              out_valid_next;
    logic [DATA_W-1:0] out_data_reg;
    logic [DATA_W-1:0] out_data_next;

    // slow_clk is a register in this clock domain, so it is sampled directly.
    // Resetting the delay to 1 suppresses a false rise when slow_clk is high at release.
    always_ff @(posedge clk) begin
        if (reset) begin
            slow_d_reg <= 1'b1;
        end else begin
            slow_d_reg <= slow_clk;
        end
    end

    assign edge_det.rise = slow_clk & ~slow_d_reg;
    assign edge_det.fall = ~slow_clk & slow_d_reg;
    assign slow_rise     = edge_det.rise;
    assign slow_fall     = edge_det.fall;

    // Pop only on a rise, and only when the output stage is empty or being drained.
    assign fifo_pop = edge_det.rise & ~fifo_empty & (~out_valid_reg | out_ready);

    xfer_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (fifo_pop) begin
            out_valid_next = 1'b1;
            out_data_next  = fifo_head;
        end else if (edge_det.rise && out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign wr_ready  = ~fifo_full;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: doc/slow_clk_xfer.md
Name: slow_clk_xfer

Overview:
- Fast-clock-domain bridge between the memory side (`clk`) and the AXI-slave side, which runs on the divided `slow_clk`.
- Takes a stream of words on `clk`, buffers them in a FIFO, and presents them to the slow-side consumer.
- The slow-side output changes only on the `clk` cycle after each detected `slow_clk` rising edge, so it is stable across the whole slow period.
- `slow_clk` is a register output in the same `clk` domain, so it is sampled directly with no synchroniser.

Parameters:
- DATA_W, 64, payload width in bits.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  input  1  fast (memory) clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided clock, sampled as data on `clk`.
- wr_valid  input  1  fast-side write request.
- wr_ready  output  1  FIFO not full.
- wr_data  input  DATA_W  fast-side write word.
- out_valid  output  1  slow-side word valid.
- out_data  output  DATA_W  slow-side word.
- out_ready  input  1  slow-side accept; driven from the slow domain and held stable per slow period.
- slow_rise  output  1  one-`clk` pulse on a detected `slow_clk` 0->1 transition.
- slow_fall  output  1  one-`clk` pulse on a detected `slow_clk` 1->0 transition.
- fifo_cnt  output  CNT_W  current FIFO occupancy.

Behaviour:
- Edge detect: `slow_d <= slow_clk` every cycle.
  - `slow_rise = slow_clk & ~slow_d`; `slow_fall = ~slow_clk & slow_d`. Both are combinational from registers.
  - `slow_d` resets to 1, so a `slow_clk` that is already high at reset release gives no spurious rise.
- Reset values: `slow_d` = 1. FIFO pointers = 0. `fifo_cnt` = 0. `out_valid` = 0. `out_data` = 0. `wr_ready` = 1 in the cycle after reset deasserts.
- Write side:
  - `wr_ready = (fifo_cnt != DEPTH)`.
  - A push occurs when `wr_valid & wr_ready`.
  - When full, `wr_ready` = 0 even if a pop happens in the same cycle (no push-through).
- Output stage: `out_valid`/`out_data` form one register stage outside the FIFO. They update only in cycles where `slow_rise` = 1:
  - If `out_valid & out_ready`, the word is consumed. The stage then reloads from the FIFO head (pop) if the FIFO is non-empty; otherwise `out_valid` <= 0.
  - If `!out_valid` and the FIFO is non-empty, load the head (pop) and set `out_valid` <= 1.
  - If `out_valid & !out_ready`, hold.
- When `slow_rise` = 0, the output stage and pop side are frozen.
- `out_ready` is sampled only in `slow_rise` cycles.
- Simultaneous push and pop: `fifo_cnt` is unchanged, the pointers advance, and both words are correct.
- Push into an empty FIFO in a `slow_rise` cycle: the word is not visible to the pop; it is loaded on the next rise. There is no bypass.
- Latency: a word written at cycle t into an empty pipe appears on `out_data` on the `clk` edge at the first `slow_rise` strictly after t, plus 1.
- Pointers are AW = log2(DEPTH) bits and wrap naturally. `fifo_cnt` never exceeds DEPTH and never underflows.
- Reset mid-operation flushes the FIFO and the output stage; in-flight words are dropped.
- Ratio: requires at least one `clk` cycle per `slow_clk` phase, i.e. a divide ratio of 2 or more.

Decomposition:
- Shared package `slow_xfer_pkg`: `DATA_W` default, `DEPTH` default, CNT_W/AW derivation functions.
- One natural sub-module: `xfer_sync_fifo`.
  - Single clock, synchronous active-high reset.
  - push/pop/full/empty/count with a registered memory.
  - Parent holds the edge detector and output stage.

Test Plan:
- Reset with `slow_clk`=1 held, then release -> `slow_rise` stays 0 until `slow_clk` goes 0 then 1. `out_valid`=0 and `fifo_cnt`=0.
- Divide ratio 4, push 0xA5 once, `out_ready`=1 -> `out_data`=0xA5, `out_valid`=1 one cycle after the next `slow_rise`, held for the full slow period; cleared at the following rise.
- Push 10 words (0..9) back-to-back, DEPTH 8, `out_ready`=0 -> `wr_ready` drops after 9 accepted (8 FIFO + 1 output stage). `fifo_cnt`=8, word 0 held on `out_data`.
- From that full state, raise `out_ready` -> one word per slow period in order 0..8; word 9 accepted on the first freed slot; no loss or duplication.
- Push in the same cycle as `slow_rise` with the FIFO and output stage empty -> word appears only after the next rise (no bypass).
- Assert `reset` mid-stream with 5 words queued -> next cycle `fifo_cnt`=0, `out_valid`=0. After release, new words 0x11, 0x22 come out in order.
